// File: rtl/flag_register_unit.sv
// flag_register_unit
//   Derives the N/Z/C/V condition flags from ALU outputs and holds them in the
//   architectural status register {Q,N,Z,C,V}. A one-deep shadow copy supports
//   save/restore on exception entry/return. flags_next exposes the value the
//   register takes at the coming edge, for back-to-back consumers.
//
//   Optional feature macro: QFLAG_EN
//     defined   -> flags[4] is a sticky saturation flag (Q).
//     undefined -> flags[4], flags_next[4] and the shadow's bit 4 are tied to 0.
module flag_register_unit #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [4:0]  RST_FLAGS = 5'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_ovf,
   input  logic             alu_sat,
   input  logic [1:0]       flag_write,
   input  logic             cond_ex,
   input  logic             stall,
   input  logic             save,
   input  logic             restore,
   output logic [4:0]       flags,
   output logic [4:0]       flags_next,
   output logic             shadow_valid
);

   // Bit positions inside the {Q,N,Z,C,V} vector.
   localparam int unsigned BIT_Q = 4;
   localparam int unsigned BIT_N = 3;
   localparam int unsigned BIT_Z = 2;
   localparam int unsigned BIT_C = 1;
   localparam int unsigned BIT_V = 0;

   // Architectural state.
   logic [4:0] flags_q;
   logic [4:0] flags_d;
   logic [4:0] shadow_q;
   logic [4:0] shadow_d;
   logic       shadow_valid_q;
   logic       shadow_valid_d;

   // Decoded controls.
   logic       upd;
   logic       upd_nz;
   logic       upd_cv;
   logic       save_en;
   logic       restore_en;

   // Raw flag values derived from the ALU this cycle.
   logic       alu_n;
   logic       alu_z;
   logic       alu_c;
   logic       alu_v;

   // Flags as they would be after the ALU update alone (restore not applied).
   logic [4:0] alu_flags;
   logic       q_next;

   // Decode the update/save/restore enables; stall freezes everything.
   always_comb begin
      upd        = alu_valid & cond_ex & ~stall;
      upd_nz     = upd & flag_write[1];
      upd_cv     = upd & flag_write[0];
      save_en    = save & ~stall;
      restore_en = restore & ~stall & shadow_valid_q;
   end

   // Derive N/Z/C/V from the ALU outputs.
   always_comb begin
      alu_n = alu_result[WIDTH-1];
      alu_z = (alu_result == '0);
      alu_c = alu_carry;
      alu_v = alu_ovf;
   end

`ifdef QFLAG_EN
   // Sticky saturation flag: set by any enabled update reporting saturation.
   always_comb begin
      q_next = flags_q[BIT_Q] | (upd & alu_sat);
   end
`else
   logic unused_alu_sat;
   assign unused_alu_sat = alu_sat;

   // Without the Q feature the top flag bit is constant zero.
   always_comb begin
      q_next = 1'b0;
   end
`endif

   // Apply the two independent flag groups; unselected bits hold.
   always_comb begin
      alu_flags        = flags_q;
      alu_flags[BIT_Q] = q_next;
      if (upd_nz) begin
         alu_flags[BIT_N] = alu_n;
         alu_flags[BIT_Z] = alu_z;
      end
      if (upd_cv) begin
         alu_flags[BIT_C] = alu_c;
         alu_flags[BIT_V] = alu_v;
      end
   end

   // A valid restore wins over any same-cycle ALU update.
   always_comb begin
      flags_d = alu_flags;
      if (restore_en) begin
         flags_d = shadow_q;
      end
   end

   // Shadow capture: a save takes the non-restored next value, which also
   // gives swap semantics when save and restore coincide.
   always_comb begin
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      if (save_en) begin
         shadow_d       = alu_flags;
         shadow_valid_d = 1'b1;
      end else if (restore_en) begin
         shadow_valid_d = 1'b0;
      end
   end

   // State registers; reset overrides stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q        <= RST_FLAGS;
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
      end else begin
         flags_q        <= flags_d;
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
      end
   end

   // Drive outputs.
   always_comb begin
      flags        = flags_q;
      flags_next   = flags_d;
      shadow_valid = shadow_valid_q;
   end

endmodule

// File: tb/tb_flag_register_unit.sv
// tb_flag_register_unit
//   Scoreboarded bench for flag_register_unit: a behavioural model predicts
//   flags/shadow_valid for each driven cycle, pushes them to a queue, and the
//   registered outputs are popped and compared after the clock edge.
module tb_flag_register_unit;

   localparam int unsigned W = 32;

   logic          clk;
   logic          reset;
   logic          alu_valid;
   logic [W-1:0]  alu_result;
   logic          alu_carry;
   logic          alu_ovf;
   logic          alu_sat;
   logic [1:0]    flag_write;
   logic          cond_ex;
   logic          stall;
   logic          save;
   logic          restore;
   logic [4:0]    flags;
   logic [4:0]    flags_next;
   logic          shadow_valid;

   int unsigned   n_vec;
   int unsigned   n_err;

   // Model state.
   logic [4:0]    m_flags;
   logic [4:0]    m_shadow;
   logic          m_sv;

   // Scoreboard entries: {flags, shadow_valid}.
   logic [5:0]    sb_q[$];

   flag_register_unit #(
      .WIDTH     (W),
      .RST_FLAGS (5'b0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_result   (alu_result),
      .alu_carry    (alu_carry),
      .alu_ovf      (alu_ovf),
      .alu_sat      (alu_sat),
      .flag_write   (flag_write),
      .cond_ex      (cond_ex),
      .stall        (stall),
      .save         (save),
      .restore      (restore),
      .flags        (flags),
      .flags_next   (flags_next),
      .shadow_valid (shadow_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Pop the oldest prediction after an edge and compare the registered outputs.
   task automatic pop_check();
      logic [5:0] e;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_val("flags", {27'd0, flags}, {27'd0, e[5:1]});
         check_val("shadow_valid", {31'd0, shadow_valid}, {31'd0, e[0]});
      end
   endtask

   // Drive one cycle of stimulus, check flags_next, predict, clock, compare.
   task automatic cycle(input logic v, input logic [W-1:0] res, input logic c, input logic o,
                        input logic s, input logic [1:0] fw, input logic ce, input logic st,
                        input logic sv, input logic rs);
      logic [4:0] an;
      logic [4:0] nf;
      logic       u;
      logic       rok;
      logic       svn;
      alu_valid  = v;
      alu_result = res;
      alu_carry  = c;
      alu_ovf    = o;
      alu_sat    = s;
      flag_write = fw;
      cond_ex    = ce;
      stall      = st;
      save       = sv;
      restore    = rs;
      #1;
      u  = v & ce & ~st;
      an = m_flags;
      if (u && fw[1]) begin
         an[3] = res[W-1];
         an[2] = (res == 0);
      end
      if (u && fw[0]) begin
         an[1] = c;
         an[0] = o;
      end
`ifdef QFLAG_EN
      an[4] = m_flags[4] | (u & s);
`else
      an[4] = 1'b0;
`endif
      rok = rs & ~st & m_sv;
      nf  = rok ? m_shadow : an;
      if (st)       svn = m_sv;
      else if (sv)  svn = 1'b1;
      else if (rok) svn = 1'b0;
      else          svn = m_sv;
      if (!st && sv) m_shadow = an;
      check_val("flags_next", {27'd0, flags_next}, {27'd0, nf});
      sb_q.push_back({nf, svn});
      m_flags = nf;
      m_sv    = svn;
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic do_reset(input logic st);
      reset = 1'b1;
      stall = st;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      stall    = 1'b0;
      m_flags  = 5'b0;
      m_shadow = 5'b0;
      m_sv     = 1'b0;
      check_val("rst_flags", {27'd0, flags}, 32'd0);
      check_val("rst_sv", {31'd0, shadow_valid}, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1; alu_valid = 1'b0; alu_result = '0; alu_carry = 1'b0; alu_ovf = 1'b0;
      alu_sat = 1'b0; flag_write = 2'b00; cond_ex = 1'b0; stall = 1'b0; save = 1'b0; restore = 1'b0;
      m_flags = 5'b0; m_shadow = 5'b0; m_sv = 1'b0;
      @(posedge clk);
      #1;
      do_reset(1'b0);

      // 1: full update with zero result and carry.
      cycle(1, 32'h0, 1, 0, 0, 2'b11, 1, 0, 0, 0);
      check_val("t1", {27'd0, flags}, 32'b00110);
      // 2: N/Z only; C/V hold.
      cycle(1, 32'h8000_0000, 0, 1, 0, 2'b10, 1, 0, 0, 0);
      check_val("t2", {27'd0, flags}, 32'b01010);
      // 3: condition failed, then stalled valid update.
      cycle(1, 32'h0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
      check_val("t3_cond", {27'd0, flags}, 32'b01010);
      cycle(1, 32'h0, 0, 0, 0, 2'b11, 1, 1, 0, 0);
      check_val("t3_stall", {27'd0, flags}, 32'b01010);
      cycle(0, 32'h0, 1, 1, 0, 2'b11, 1, 0, 0, 0);
      check_val("t3_novalid", {27'd0, flags}, 32'b01010);
      // 4: save, update, restore beating a same-cycle update.
      cycle(1, 32'h0, 1, 0, 0, 2'b11, 1, 0, 0, 0);
      cycle(0, 32'h0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
      check_val("t4_sv", {31'd0, shadow_valid}, 32'd1);
      cycle(1, 32'h8000_0000, 0, 0, 0, 2'b11, 1, 0, 0, 0);
      check_val("t4_upd", {27'd0, flags}, 32'b01000);
      cycle(1, 32'h8000_0000, 1, 1, 0, 2'b11, 1, 0, 0, 1);
      check_val("t4_rest", {27'd0, flags}, 32'b00110);
      check_val("t4_sv0", {31'd0, shadow_valid}, 32'd0);
      // 5: restore with empty shadow is ignored.
      cycle(1, 32'h5, 0, 0, 0, 2'b11, 1, 0, 0, 1);
      check_val("t5", {27'd0, flags}, 32'b00000);
      check_val("t5_sv", {31'd0, shadow_valid}, 32'd0);
      // Swap: save+restore together.
      cycle(1, 32'h0, 1, 1, 0, 2'b11, 1, 0, 1, 0);   // flags 00111, shadow 00111
      cycle(1, 32'h8000_0000, 0, 0, 0, 2'b11, 1, 0, 0, 0); // flags 01000
      cycle(1, 32'h1, 1, 0, 0, 2'b11, 1, 0, 1, 1);   // flags<=00111, shadow<=00010
      check_val("swap_flags", {27'd0, flags}, 32'b00111);
      check_val("swap_sv", {31'd0, shadow_valid}, 32'd1);
      cycle(0, 32'h0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      check_val("swap_back", {27'd0, flags}, 32'b00010);
      // 6: saturation with flag_write=0.
      cycle(1, 32'h1, 0, 0, 1, 2'b00, 1, 0, 0, 0);
`ifdef QFLAG_EN
      check_val("t6_q", {31'd0, flags[4]}, 32'd1);
`else
      check_val("t6_q", {31'd0, flags[4]}, 32'd0);
`endif
      cycle(1, 32'h0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
`ifdef QFLAG_EN
      check_val("t6_sticky", {31'd0, flags[4]}, 32'd1);
`else
      check_val("t6_sticky", {31'd0, flags[4]}, 32'd0);
`endif
      // Reset overrides stall.
      do_reset(1'b1);

      // Randomised traffic through the scoreboard.
      for (int i = 0; i < 300; i++) begin
         logic [W-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
         cycle(1'($urandom_range(0, 3) != 0), r, 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 7) == 0), 2'($urandom), 1'($urandom_range(0, 4) != 0),
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 5) == 0));
      end

      check_val("sb_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
